// File: rtl/adder_share_scheduler.sv
// Round-robin sharing of a single 3-bit ripple-carry adder among NUM_CH counter channels.
// Winner's count/step drive the adder; sum written back, carry-out feeds per-channel overflow.

module three_bit_adder (
  input  logic [2:0] a,
  input  logic [2:0] b,
  input  logic       cin,
  output logic [2:0] s,
  output logic       cout
);
  logic [3:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 3; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[3];
endmodule

module adder_share_scheduler #(
  parameter int NUM_CH     = 4,
  parameter int STICKY_OVF = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_CH-1:0]   req,
  input  logic [3*NUM_CH-1:0] step,
  input  logic [NUM_CH-1:0]   clr,
  output logic [NUM_CH-1:0]   gnt,
  output logic [3*NUM_CH-1:0] count,
  output logic [NUM_CH-1:0]   ovf,
  output logic                busy
);
  localparam int PW = $clog2(NUM_CH);

  logic [2:0]        cnt_q  [NUM_CH];
  logic [2:0]        step_a [NUM_CH];
  logic [NUM_CH-1:0] eligible;
  logic [NUM_CH-1:0] win_oh;
  logic              found;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     win_idx;
  logic [2:0]        add_a;
  logic [2:0]        add_b;
  logic [2:0]        sum;
  logic              cout;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign step_a[i]       = step[3*i +: 3];
    assign count[3*i +: 3] = cnt_q[i];
  end

  // A channel granted last cycle (gnt high) sits out one arbitration round.
  assign eligible = req & ~gnt & ~clr;
  assign busy     = |eligible;

  always_comb begin : p_arb
    logic [PW-1:0] cand;
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      cand = PW'((32'(ptr) + k) % 32'(NUM_CH));
      if (!found && eligible[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
    win_oh = '0;
    if (found) win_oh[win_idx] = 1'b1;
    add_a = found ? cnt_q[win_idx]  : '0;
    add_b = found ? step_a[win_idx] : '0;
  end

  three_bit_adder u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (1'b0),
    .s    (sum),
    .cout (cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
      ovf <= '0;
      gnt <= '0;
      ptr <= PW'(NUM_CH - 1);
    end else begin
      gnt <= win_oh;
      if (found) ptr <= win_idx;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (clr[i]) begin
          cnt_q[i] <= '0;
          ovf[i]   <= 1'b0;
        end else if (win_oh[i]) begin
          cnt_q[i] <= sum;
          ovf[i]   <= (STICKY_OVF != 0) ? (ovf[i] | cout) : cout;
        end
      end
    end
  end
endmodule

// File: tb/tb_adder_share_scheduler.sv
// Bench for adder_share_scheduler: directed scenarios then random traffic against an
// arithmetic reference model of the round-robin counters.

module tb_adder_share_scheduler;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [3*N-1:0] step;
  logic [N-1:0]   clr;
  logic [N-1:0]   gnt;
  logic [3*N-1:0] count;
  logic [N-1:0]   ovf;
  logic           busy;

  int          m_cnt [N];
  bit          m_ovf [N];
  logic [N-1:0] m_gnt;
  int          m_ptr;
  int          total  = 0;
  int          passed = 0;
  int          failed = 0;

  always #5 clk = ~clk;

  adder_share_scheduler #(.NUM_CH(N), .STICKY_OVF(1)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .step  (step),
    .clr   (clr),
    .gnt   (gnt),
    .count (count),
    .ovf   (ovf),
    .busy  (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3*N-1:0] exp_count();
    logic [3*N-1:0] v;
    for (int i = 0; i < N; i++) v[3*i +: 3] = 3'(m_cnt[i]);
    return v;
  endfunction

  function automatic logic [N-1:0] exp_ovf();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_ovf[i];
    return v;
  endfunction

  task automatic set_step(input int ch, input int v);
    step[3*ch +: 3] = 3'(v);
  endtask

  // One clock cycle: predict from current inputs, clock, then compare all outputs.
  task automatic tick();
    logic [N-1:0] elig;
    int w;
    int c;
    int s;
    #1;
    elig = req & ~m_gnt & ~clr;
    if (!rst) chk("busy", 32'(busy), 32'(|elig));
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_cnt[i] = 0;
        m_ovf[i] = 1'b0;
      end
      m_gnt = '0;
      m_ptr = N - 1;
    end else begin
      w = -1;
      for (int k = 1; k <= N; k++) begin
        c = (m_ptr + k) % N;
        if (w < 0 && elig[c]) w = c;
      end
      for (int i = 0; i < N; i++) begin
        if (clr[i]) begin
          m_cnt[i] = 0;
          m_ovf[i] = 1'b0;
        end
      end
      if (w >= 0) begin
        s        = m_cnt[w] + int'(step[3*w +: 3]);
        m_cnt[w] = s % 8;
        m_ovf[w] = m_ovf[w] | (s >= 8);
        m_ptr    = w;
        m_gnt    = '0;
        m_gnt[w] = 1'b1;
      end else begin
        m_gnt = '0;
      end
    end
    @(posedge clk);
    #1;
    chk("gnt",   32'(gnt),   32'(m_gnt));
    chk("count", 32'(count), 32'(exp_count()));
    chk("ovf",   32'(ovf),   32'(exp_ovf()));
  endtask

  initial begin
    rst  = 1'b1;
    req  = 4'b1111;
    step = '0;
    clr  = '0;
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0;
      m_ovf[i] = 1'b0;
    end
    m_gnt = '0;
    m_ptr = N - 1;

    // Reset held with all requests
    repeat (2) begin
      tick();
      chk("rst_gnt",   32'(gnt),   32'h0);
      chk("rst_count", 32'(count), 32'h0);
      chk("rst_ovf",   32'(ovf),   32'h0);
    end
    rst = 1'b0;
    req = '0;

    // Single channel: count_2 = 2, then += 3
    req = 4'b0100; set_step(2, 2); tick();
    req = '0; tick();
    req = 4'b0100; set_step(2, 3); tick();
    chk("single_gnt",  32'(gnt),        32'h4);
    chk("single_cnt2", 32'(count[8:6]), 32'd5);
    chk("single_ovf2", 32'(ovf[2]),     32'd0);
    req = '0; tick();

    // Wrap with sticky overflow, then clear
    req = 4'b0010; set_step(1, 6); tick();
    req = '0; tick();
    req = 4'b0010; set_step(1, 3); tick();
    chk("wrap_cnt1", 32'(count[5:3]), 32'd1);
    chk("wrap_ovf1", 32'(ovf[1]),     32'd1);
    req = '0; tick();
    req = 4'b0010; set_step(1, 1); tick();
    chk("sticky_cnt1", 32'(count[5:3]), 32'd2);
    chk("sticky_ovf1", 32'(ovf[1]),     32'd1);
    req = '0; clr = 4'b0010; tick();
    clr = '0;
    chk("clr_cnt1", 32'(count[5:3]), 32'd0);
    chk("clr_ovf1", 32'(ovf[1]),     32'd0);

    // Zero step on ch3 (also parks pointer at 3)
    clr = 4'b1111; tick();
    clr = '0;
    req = 4'b1000; set_step(3, 0); tick();
    chk("zstep_gnt",  32'(gnt),          32'h8);
    chk("zstep_cnt3", 32'(count[11:9]),  32'd0);
    req = '0; tick();

    // Round-robin rotation with all requests held
    req = 4'b1111;
    for (int i = 0; i < N; i++) set_step(i, 1);
    tick(); chk("rr0", 32'(gnt), 32'h1);
    tick(); chk("rr1", 32'(gnt), 32'h2);
    tick(); chk("rr2", 32'(gnt), 32'h4);
    tick(); chk("rr3", 32'(gnt), 32'h8);
    tick(); chk("rr4", 32'(gnt), 32'h1);
    chk("rr_counts", 32'(count), 32'h24A);
    req = '0; tick();

    // Clear/grant collision on ch0 with pointer at 3
    req = 4'b1000; tick();
    req = '0; tick();
    req = 4'b0001; set_step(0, 5); clr = 4'b0001; tick();
    chk("coll_gnt",  32'(gnt),        32'h0);
    chk("coll_cnt0", 32'(count[2:0]), 32'd0);
    clr = '0; tick();
    chk("coll_gnt2", 32'(gnt),        32'h1);
    chk("coll_cnt0b", 32'(count[2:0]), 32'd5);
    req = '0; tick();

    // Reset arriving with an in-flight request
    req = 4'b1000; set_step(3, 2); rst = 1'b1; tick();
    chk("rmid_gnt",  32'(gnt),          32'h0);
    chk("rmid_cnt3", 32'(count[11:9]),  32'd0);
    rst = 1'b0; tick();
    chk("rmid_gnt2", 32'(gnt),          32'h8);
    chk("rmid_cnt3b", 32'(count[11:9]), 32'd2);
    req = '0; tick();

    // Random traffic
    for (int it = 0; it < 400; it++) begin
      req  = N'($urandom);
      step = (3*N)'($urandom);
      clr  = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      rst  = ($urandom_range(0, 59) == 0);
      tick();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
